// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI TMDS encoder: q_m stage, then symbol/disparity stage, plus optional output register.
// Latency 2 pclk (OUT_REG=0) or 3 pclk (OUT_REG=1); one symbol per channel per clock, never stalls.

module tmds_channel (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       de_s1,
    input  logic [1:0] ctl_s1,
    output logic [9:0] sym
);
    logic [8:0]        qm;
    logic [8:0]        qm_nxt;
    logic [3:0]        n1_d;
    logic              use_xnor;
    logic [3:0]        n1;
    logic [4:0]        two_n1;
    logic signed [4:0] diff;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nxt;
    logic [9:0]        sym_nxt;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
    always_comb begin
        n1_d     = ones8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        qm_nxt   = '0;
        qm_nxt[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm_nxt[i] = use_xnor ? ~(qm_nxt[i-1] ^ d[i]) : (qm_nxt[i-1] ^ d[i]);
        qm_nxt[8] = ~use_xnor;
    end

    // 5-bit wraparound in the intermediate sums is harmless: every result lands in -10..+10.
    always_comb begin
        n1     = ones8(qm[7:0]);
        two_n1 = {n1, 1'b0};
        diff   = $signed(two_n1 - 5'd8);
        if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
            sym_nxt = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_nxt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
            sym_nxt = {1'b1, qm[8], ~qm[7:0]};
            cnt_nxt = cnt - diff + (qm[8] ? 5'sd2 : 5'sd0);
        end else begin
            sym_nxt = {1'b0, qm[8], qm[7:0]};
            cnt_nxt = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        if (!de_s1) begin
            sym_nxt = ctl_code(ctl_s1);
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            qm  <= '0;
            sym <= 10'h354;
            cnt <= '0;
        end else begin
            qm  <= qm_nxt;
            sym <= sym_nxt;
            cnt <= cnt_nxt;
        end
    end
endmodule

module tmds_encoder_rgb #(
    parameter int OUT_REG = 1
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] vid_r,
    input  logic [7:0] vid_g,
    input  logic [7:0] vid_b,
    input  logic       vid_hs,
    input  logic       vid_vs,
    input  logic       vid_de,
    output logic [9:0] tmds_b,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_r
);
    logic       de_s1;
    logic       hs_s1;
    logic       vs_s1;
    logic [9:0] sym_b;
    logic [9:0] sym_g;
    logic [9:0] sym_r;

    always_ff @(posedge pclk) begin
        if (!rst) begin
            de_s1 <= 1'b0;
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
        end else begin
            de_s1 <= vid_de;
            hs_s1 <= vid_hs;
            vs_s1 <= vid_vs;
        end
    end

    tmds_channel u_ch_b (.pclk(pclk), .rst(rst), .d(vid_b), .de_s1(de_s1), .ctl_s1({vs_s1, hs_s1}), .sym(sym_b));
    tmds_channel u_ch_g (.pclk(pclk), .rst(rst), .d(vid_g), .de_s1(de_s1), .ctl_s1(2'b00),          .sym(sym_g));
    tmds_channel u_ch_r (.pclk(pclk), .rst(rst), .d(vid_r), .de_s1(de_s1), .ctl_s1(2'b00),          .sym(sym_r));

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge pclk) begin
                if (!rst) begin
                    tmds_b <= 10'h354;
                    tmds_g <= 10'h354;
                    tmds_r <= 10'h354;
                end else begin
                    tmds_b <= sym_b;
                    tmds_g <= sym_g;
                    tmds_r <= sym_r;
                end
            end
        end else begin : g_comb
            assign tmds_b = sym_b;
            assign tmds_g = sym_g;
            assign tmds_r = sym_r;
        end
    endgenerate
endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Directed and model-based bench for tmds_encoder_rgb with the output register enabled (latency 3).

module tb_tmds_encoder_rgb;
    logic       pclk = 1'b0;
    logic       rst;
    logic [7:0] vid_r, vid_g, vid_b;
    logic       vid_hs, vid_vs, vid_de;
    logic [9:0] tmds_b, tmds_g, tmds_r;

    int checks = 0;
    int errors = 0;

    tmds_encoder_rgb #(.OUT_REG(1)) dut (
        .pclk(pclk), .rst(rst),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [9:0] eb, eg, er;
        logic       de;
        logic [7:0] db, dg, dr;
    } exp_t;

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vid_de = de; vid_hs = hs; vid_vs = vs;
        vid_r = r; vid_g = g; vid_b = b;
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
    endtask

    function automatic int ones10(input logic [9:0] s);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic vs, input logic hs);
        logic [9:0] t [4];
        t = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        return t[{vs, hs}];
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] d, input int cnt);
        logic [8:0] q;
        int         nd = 0;
        int         n1 = 0;
        logic       xn;
        for (int i = 0; i < 8; i++) nd += int'(d[i]);
        xn   = (nd > 4) || (nd == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xn;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        if (cnt == 0 || n1 == 4)
            return q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
        else if ((cnt > 0 && n1 > 4) || (cnt < 0 && n1 < 4))
            return {1'b1, q[8], ~q[7:0]};
        else
            return {1'b0, q[8], q[7:0]};
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'h5A, 8'hC3, 8'h81);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL reset_b got %h want 354", tmds_b); end
        checks++; if (tmds_g !== 10'h354) begin errors++; $display("FAIL reset_g got %h want 354", tmds_g); end
        checks++; if (tmds_r !== 10'h354) begin errors++; $display("FAIL reset_r got %h want 354", tmds_r); end
        rst = 1'b1;
    endtask

    task automatic test_control_codes();
        logic [9:0] exp_tab [4];
        exp_tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] c;
            c = 2'(i);
            repeat (3) drive(1'b0, c[0], c[1], 8'hFF, 8'hFF, 8'hFF);
            checks++;
            if (tmds_b !== exp_tab[i] || tmds_g !== 10'h354 || tmds_r !== 10'h354) begin
                errors++;
                $display("FAIL ctl_%0d got b=%h g=%h r=%h want b=%h g=354 r=354", i, tmds_b, tmds_g, tmds_r, exp_tab[i]);
            end
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL ctl_pulse_early got %h want 354", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h2AB) begin errors++; $display("FAIL ctl_pulse_lat got %h want 2ab", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL ctl_pulse_after got %h want 354", tmds_b); end
    endtask

    task automatic test_zero_run();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL zero_early got %h want 354", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h100 || tmds_g !== 10'h100) begin errors++; $display("FAIL zero_p1 got b=%h g=%h want 100", tmds_b, tmds_g); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h3FF || tmds_r !== 10'h3FF) begin errors++; $display("FAIL zero_p2 got b=%h r=%h want 3ff", tmds_b, tmds_r); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL zero_blank got %h want 354", tmds_b); end
    endtask

    task automatic test_all_ones();
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF, 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (tmds_b !== 10'h200 || tmds_g !== 10'h200 || tmds_r !== 10'h1F0) begin
            errors++; $display("FAIL ones_p1 got b=%h g=%h r=%h want b=200 g=200 r=1f0", tmds_b, tmds_g, tmds_r);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h0FF) begin errors++; $display("FAIL ones_p2 got %h want 0ff", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_disparity_clear();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h100) begin errors++; $display("FAIL clr_p1 got %h want 100", tmds_b); end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h3FF) begin errors++; $display("FAIL clr_p2 got %h want 3ff", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL clr_blank got %h want 354", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h100) begin errors++; $display("FAIL clr_p3 got %h want 100", tmds_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (tmds_b !== 10'h354 || tmds_g !== 10'h354 || tmds_r !== 10'h354) begin
            errors++; $display("FAIL rmid_rst got b=%h g=%h r=%h want 354", tmds_b, tmds_g, tmds_r);
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL rmid_stale1 got %h want 354", tmds_b); end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h354) begin errors++; $display("FAIL rmid_stale2 got %h want 354", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h100) begin errors++; $display("FAIL rmid_p1 got %h want 100", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        checks++; if (tmds_b !== 10'h3FF) begin errors++; $display("FAIL rmid_p2 got %h want 3ff", tmds_b); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        exp_t       q [$];
        exp_t       e;
        exp_t       p;
        int         mc [3];
        int         od [3];
        logic [9:0] obs [3];
        logic [7:0] din [3];
        logic [9:0] ex  [3];
        do_reset();
        mc = '{0, 0, 0};
        od = '{0, 0, 0};
        p  = '{eb: 10'h354, eg: 10'h354, er: 10'h354, de: 1'b0, db: 8'h00, dg: 8'h00, dr: 8'h00};
        q.push_back(p);
        q.push_back(p);
        for (int n = 0; n < 4000; n++) begin
            logic de, hs, vs;
            de = ($urandom_range(0, 9) != 0);
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            din[0] = 8'($urandom); din[1] = 8'($urandom); din[2] = 8'($urandom);
            for (int c = 0; c < 3; c++) begin
                if (de) begin
                    ex[c] = enc(din[c], mc[c]);
                    mc[c] += 2 * ones10(ex[c]) - 10;
                end else begin
                    ex[c] = (c == 0) ? ctl_sym(vs, hs) : 10'h354;
                    mc[c] = 0;
                end
            end
            p = '{eb: ex[0], eg: ex[1], er: ex[2], de: de, db: din[0], dg: din[1], dr: din[2]};
            q.push_back(p);
            drive(de, hs, vs, din[2], din[1], din[0]);
            e = q.pop_front();
            checks++;
            if (tmds_b !== e.eb || tmds_g !== e.eg || tmds_r !== e.er) begin
                errors++;
                if (errors < 20) $display("FAIL rand_sym[%0d] got b=%h g=%h r=%h want b=%h g=%h r=%h",
                                          n, tmds_b, tmds_g, tmds_r, e.eb, e.eg, e.er);
            end
            obs[0] = tmds_b; obs[1] = tmds_g; obs[2] = tmds_r;
            if (e.de) begin
                checks++;
                if (dec(tmds_b) !== e.db || dec(tmds_g) !== e.dg || dec(tmds_r) !== e.dr) begin
                    errors++;
                    if (errors < 20) $display("FAIL rand_decode[%0d] got %h %h %h want %h %h %h",
                                              n, dec(tmds_b), dec(tmds_g), dec(tmds_r), e.db, e.dg, e.dr);
                end
                for (int c = 0; c < 3; c++) od[c] += 2 * ones10(obs[c]) - 10;
                checks++;
                if (od[0] > 10 || od[0] < -10 || od[1] > 10 || od[1] < -10 || od[2] > 10 || od[2] < -10) begin
                    errors++;
                    if (errors < 20) $display("FAIL rand_disp[%0d] got %0d %0d %0d want within +-10", n, od[0], od[1], od[2]);
                end
            end else begin
                od = '{0, 0, 0};
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0;
        vid_r = 8'h00; vid_g = 8'h00; vid_b = 8'h00;
        #1;
        test_reset();
        test_control_codes();
        test_zero_run();
        test_all_ones();
        test_disparity_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
